// File: rtl/conv_window_mac.sv
// conv_window_mac: row-at-a-time convolution window multiply-accumulate.
// Accepts a KMAX x KMAX window/filter pair and processes one row per cycle.
// The result is shifted down by FRAC, then saturated to DW bits.
// Optional build macro: CONV_WINDOW_RELU_EN clamps negative results to zero.

// Per-column multiplier; columns outside the active edge contribute zero.
module conv_window_mac_lane #(
  parameter int DW = 16
) (
  input  logic                   en,
  input  logic [DW-1:0]          a,
  input  logic [DW-1:0]          b,
  output logic signed [2*DW-1:0] p
);
  // Full-width signed product, gated by column enable
  always_comb begin
    p = '0;
    if (en) p = $signed(a) * $signed(b);
  end
endmodule

module conv_window_mac #(
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int KMAX = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [KMAX*KMAX*DW-1:0]  window,
  input  logic [KMAX*KMAX*DW-1:0]  filter,
  input  logic [7:0]               filter_size,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            value,
  output logic                     busy
);
  localparam int NE = KMAX * KMAX;
  localparam int AW = 2 * DW + $clog2(NE);
  localparam int KW = $clog2(KMAX + 1);

  localparam logic signed [AW-1:0] VMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] VMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                       state_q, state_d;
  logic [NE-1:0][DW-1:0]        win_q, flt_q;
  logic [KW-1:0]                k_q, row_q, k_eff;
  logic signed [AW-1:0]         acc_q;
  logic [DW-1:0]                value_q;

  logic [KMAX-1:0][DW-1:0]      row_w, row_f;
  logic signed [2*DW-1:0]       prod [KMAX];
  logic signed [AW-1:0]         row_sum, shifted;
  logic [DW-1:0]                sat, res;

  // Effective edge: oversized requests clamp to KMAX
  always_comb begin
    k_eff = filter_size[KW-1:0];
    if (filter_size > 8'(KMAX)) k_eff = KW'(KMAX);
  end

  // Select the current row of window and filter
  always_comb begin
    row_w = '0;
    row_f = '0;
    for (int r = 0; r < KMAX; r++) begin
      if (row_q == KW'(r)) begin
        for (int c = 0; c < KMAX; c++) begin
          row_w[c] = win_q[r*KMAX+c];
          row_f[c] = flt_q[r*KMAX+c];
        end
      end
    end
  end

  for (genvar c = 0; c < KMAX; c++) begin : g_lane
    conv_window_mac_lane #(.DW(DW)) u_lane (
      .en (KW'(c) < k_q),
      .a  (row_w[c]),
      .b  (row_f[c]),
      .p  (prod[c])
    );
  end

  // Sign-extend and sum the column products of the current row
  always_comb begin
    row_sum = '0;
    for (int c = 0; c < KMAX; c++)
      row_sum = row_sum + {{(AW-2*DW){prod[c][2*DW-1]}}, prod[c]};
  end

  // Floor-shift out the fraction, saturate, optionally clamp negatives
  always_comb begin
    shifted = acc_q >>> FRAC;
    sat     = shifted[DW-1:0];
    if (shifted > VMAX) sat = VMAX[DW-1:0];
    else if (shifted < VMIN) sat = VMIN[DW-1:0];
`ifdef CONV_WINDOW_RELU_EN
    res = sat[DW-1] ? '0 : sat;
`else
    res = sat;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (k_eff == '0) ? DONE : ACC;
      end
      ACC: begin
        // One extra cycle after the last row registers the result
        if (row_q >= k_q) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Job capture, row accumulation and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= '0;
      flt_q   <= '0;
      k_q     <= '0;
      row_q   <= '0;
      acc_q   <= '0;
      value_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            win_q <= window;
            flt_q <= filter;
            k_q   <= k_eff;
            row_q <= '0;
            acc_q <= '0;
            if (k_eff == '0) value_q <= '0;
          end
        end
        ACC: begin
          if (row_q < k_q) begin
            acc_q <= acc_q + row_sum;
            row_q <= row_q + 1'b1;
          end else begin
            value_q <= res;
          end
        end
        default: ;
      endcase
    end
  end

  assign value = value_q;
endmodule

// File: tb/tb_conv_window_mac.sv
// Directed bench for conv_window_mac at default parameters (Q8.8, KMAX=5).
module tb_conv_window_mac;
  localparam int DW = 16;
  localparam int KMAX = 5;
  localparam int BW = KMAX * KMAX * DW;
`ifdef CONV_WINDOW_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] window = '0;
  logic [BW-1:0] filter = '0;
  logic [7:0]    filter_size = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] value;
  logic          busy;

  int checks = 0;
  int errors = 0;

  conv_window_mac #(.DW(DW), .FRAC(8), .KMAX(KMAX)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .window(window), .filter(filter), .filter_size(filter_size),
    .out_valid(out_valid), .out_ready(out_ready), .value(value), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] fill(input logic [DW-1:0] v);
    logic [BW-1:0] f;
    for (int i = 0; i < KMAX*KMAX; i++) f[i*DW +: DW] = v;
    return f;
  endfunction

  function automatic logic [BW-1:0] one(input int idx, input logic [DW-1:0] v);
    logic [BW-1:0] f;
    f = '0;
    f[idx*DW +: DW] = v;
    return f;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer a job, keep offering junk while busy, measure latency, check, drain
  task automatic run_job(input string tag, input logic [BW-1:0] w, input logic [BW-1:0] f,
                         input logic [7:0] fs, input int exp_lat, input logic [DW-1:0] exp_val);
    int lat;
    window = w; filter = f; filter_size = fs; in_valid = 1'b1;
    @(posedge clk); #1;
    window = ~w; filter = ~f; filter_size = 8'd2;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_val"}, 32'(value), 32'(exp_val));
    check({tag, "_inrdy_done"}, 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_inrdy_after"}, 32'(in_ready), 32'd1);
    check({tag, "_ovld_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [BW-1:0] w;
    int lat;

    // Reset values; a job offered during reset must be ignored
    in_valid = 1'b1; window = fill(16'h0100); filter = fill(16'h0100); filter_size = 8'd3;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("rst_inrdy", 32'(in_ready), 32'd1);
    check("rst_ovld", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_val", 32'(value), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_job("k3_ones", fill(16'h0100), fill(16'h0100), 8'd3, 4, 16'h0900);
    run_job("k1_neg", one(0, 16'h0200), one(0, 16'hFF00), 8'd1, 2, RELU ? 16'h0000 : 16'hFE00);
    run_job("k5_satpos", fill(16'h7FFF), fill(16'h7FFF), 8'd5, 6, 16'h7FFF);
    run_job("k5_satneg", fill(16'h7FFF), fill(16'h8000), 8'd5, 6, RELU ? 16'h0000 : 16'h8000);
    run_job("fs9_clamp", fill(16'h0100), fill(16'h0100), 8'd9, 6, 16'h1900);
    run_job("fs5", fill(16'h0100), fill(16'h0100), 8'd5, 6, 16'h1900);
    run_job("k0", fill(16'h0300), fill(16'h0100), 8'd0, 0, 16'h0000);
    run_job("floor", one(0, 16'h0001), one(0, 16'hFFFF), 8'd1, 2, RELU ? 16'h0000 : 16'hFFFF);
    // Rows/cols beyond K=2 are nonzero and must be masked: 1+2+3+4 = 10.0
    w = fill(16'h0100);
    w[0*DW +: DW] = 16'h0100; w[1*DW +: DW] = 16'h0200;
    w[5*DW +: DW] = 16'h0300; w[6*DW +: DW] = 16'h0400;
    run_job("k2_mask", w, fill(16'h0100), 8'd2, 3, 16'h0A00);

    // Backpressure: DONE holds under out_ready=0
    window = fill(16'h0100); filter = fill(16'h0100); filter_size = 8'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hold_lat", 32'(lat), 32'd2);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_ovld", 32'(out_valid), 32'd1);
      check("hold_val", 32'(value), 32'h0100);
      check("hold_inrdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold_release_inrdy", 32'(in_ready), 32'd1);
    check("hold_release_val", 32'(value), 32'h0100);

    // Reset in the second ACC cycle discards the job
    window = fill(16'h0100); filter = fill(16'h0100); filter_size = 8'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    check("midrst_inrdy", 32'(in_ready), 32'd1);
    check("midrst_ovld", 32'(out_valid), 32'd0);
    check("midrst_val", 32'(value), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst_idle", 32'(busy), 32'd0);
    run_job("post_rst", fill(16'h0200), fill(16'h0100), 8'd2, 3, 16'h0800);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
